// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the reset sequencer: FSM state encoding,
// stage-index width and the stage-count ceiling.
package reset_seq_pkg;

  localparam int MAX_STAGES  = 8;
  localparam int STAGE_IDX_W = 3;

  typedef logic [STAGE_IDX_W-1:0] stage_idx_t;

  typedef enum logic [2:0] {
    ST_HOLD   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_DONE   = 3'd3,
    ST_FAULT  = 3'd4
  } seq_state_e;

endpackage

// File: rtl/reset_sequencer_if.sv
// Signal bundle between the reset sequencer (master) and the sequenced
// subsystems plus supervisor (slave).
interface reset_sequencer_if
  import reset_seq_pkg::*;
#(
  parameter int NUM_STAGES = 4
);

  // Handshake: iStage_Ready[k] is a level held high by subsystem k while it is
  // up (no acknowledge); iRetry is a one-cycle request honoured only in FAULT;
  // every master output is a registered level that changes on the clock edge.
  logic [NUM_STAGES-1:0] iStage_Ready;
  logic                  iRetry;
  logic [NUM_STAGES-1:0] oReset_En;
  logic                  oAll_Ready;
  logic                  oFault;
  stage_idx_t            oFault_Stage;
  seq_state_e            dbg_state;

  modport master (
    input  iStage_Ready,
    input  iRetry,
    output oReset_En,
    output oAll_Ready,
    output oFault,
    output oFault_Stage,
    output dbg_state
  );

  modport slave (
    output iStage_Ready,
    output iRetry,
    input  oReset_En,
    input  oAll_Ready,
    input  oFault,
    input  oFault_Stage,
    input  dbg_state
  );

endinterface

// File: rtl/seq_down_counter.sv
// Loadable down-counter shared by every timed sequencer state; it parks at
// zero and flags it so the FSM can exit on the cycle the count reaches 0.
module seq_down_counter #(
  parameter int CNT_W = 24
) (
  input  logic             clk_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] value_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (load_i) begin
      cnt_q <= value_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/reset_sequencer.sv
// Power-up reset scheduler: releases per-stage run enables in index order,
// waiting for each stage's ready plus a settle delay, and flags timeouts.
// Optional macro RESET_SEQ_RESEQ_ON_LOSS_EN re-sequences from the lowest lost
// stage when a ready drops in DONE.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_STAGES     = 4,
  parameter int HOLD_CYCLES    = 131072,
  parameter int SETTLE_CYCLES  = 1024,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int CNT_W          = 24
) (
  input  logic               iClk,
  input  logic               iReset,
  reset_sequencer_if.master  bus
);

  localparam stage_idx_t       LAST_IDX     = stage_idx_t'(NUM_STAGES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

  seq_state_e            state_q;
  stage_idx_t            idx_q;
  logic [NUM_STAGES-1:0] en_q;
  logic                  all_ready_q;
  logic                  fault_q;
  stage_idx_t            fault_stage_q;

  logic                  cnt_load;
  logic [CNT_W-1:0]      cnt_d;
  logic                  cnt_zero;

  logic [NUM_STAGES-1:0] stage_bit;
  logic                  cur_ready;
  logic                  last_stage;

  // One-hot of the current stage; ready bits above idx never reach the FSM.
  assign stage_bit  = NUM_STAGES'(1) << idx_q;
  assign cur_ready  = |(bus.iStage_Ready & stage_bit);
  assign last_stage = (idx_q == LAST_IDX);

`ifdef RESET_SEQ_RESEQ_ON_LOSS_EN
  logic                  loss_any;
  stage_idx_t            loss_idx;
  logic [NUM_STAGES-1:0] keep_mask;

  always_comb begin
    loss_any = 1'b0;
    loss_idx = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (!bus.iStage_Ready[i]) begin
        loss_any = 1'b1;
        loss_idx = stage_idx_t'(i);
      end
    end
  end

  assign keep_mask = (NUM_STAGES'(1) << loss_idx) - NUM_STAGES'(1);
`endif

  // Counter reloads mirror exactly the FSM transitions into a timed state.
  always_comb begin
    cnt_load = 1'b0;
    cnt_d    = HOLD_LOAD;
    if (iReset) begin
      cnt_load = 1'b1;
      cnt_d    = HOLD_LOAD;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (cnt_zero) begin
            cnt_load = 1'b1;
            cnt_d    = TIMEOUT_LOAD;
          end
        end
        ST_WAIT: begin
          if (cur_ready) begin
            cnt_load = 1'b1;
            cnt_d    = SETTLE_LOAD;
          end
        end
        ST_SETTLE: begin
          if (cnt_zero && !last_stage) begin
            cnt_load = 1'b1;
            cnt_d    = TIMEOUT_LOAD;
          end
        end
        ST_DONE: begin
`ifdef RESET_SEQ_RESEQ_ON_LOSS_EN
          if (loss_any) begin
            cnt_load = 1'b1;
            cnt_d    = HOLD_LOAD;
          end
`endif
        end
        ST_FAULT: begin
          if (bus.iRetry) begin
            cnt_load = 1'b1;
            cnt_d    = HOLD_LOAD;
          end
        end
        default: begin
          cnt_load = 1'b1;
          cnt_d    = HOLD_LOAD;
        end
      endcase
    end
  end

  seq_down_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk_i  (iClk),
    .load_i (cnt_load),
    .value_i(cnt_d),
    .zero_o (cnt_zero)
  );

  always_ff @(posedge iClk) begin
    if (iReset) begin
      state_q       <= ST_HOLD;
      idx_q         <= '0;
      en_q          <= '0;
      all_ready_q   <= 1'b0;
      fault_q       <= 1'b0;
      fault_stage_q <= '0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (cnt_zero) begin
            state_q <= ST_WAIT;
            en_q    <= en_q | stage_bit;
          end
        end
        ST_WAIT: begin
          if (cur_ready) begin
            state_q <= ST_SETTLE;
          end else if (cnt_zero) begin
            state_q       <= ST_FAULT;
            fault_q       <= 1'b1;
            fault_stage_q <= idx_q;
            en_q          <= '0;
          end
        end
        ST_SETTLE: begin
          if (cnt_zero) begin
            if (last_stage) begin
              state_q     <= ST_DONE;
              all_ready_q <= 1'b1;
            end else begin
              state_q <= ST_WAIT;
              idx_q   <= idx_q + stage_idx_t'(1);
              en_q    <= en_q | (stage_bit << 1);
            end
          end
        end
        ST_DONE: begin
`ifdef RESET_SEQ_RESEQ_ON_LOSS_EN
          // Lower stages stay up; everything from the lost stage upward restarts.
          if (loss_any) begin
            state_q     <= ST_HOLD;
            idx_q       <= loss_idx;
            en_q        <= en_q & keep_mask;
            all_ready_q <= 1'b0;
          end
`endif
        end
        ST_FAULT: begin
          if (bus.iRetry) begin
            state_q <= ST_HOLD;
            idx_q   <= '0;
            fault_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_HOLD;
          idx_q       <= '0;
          en_q        <= '0;
          all_ready_q <= 1'b0;
          fault_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.oReset_En    = en_q;
  assign bus.oAll_Ready   = all_ready_q;
  assign bus.oFault       = fault_q;
  assign bus.oFault_Stage = fault_stage_q;
  assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer (2 stages, HOLD=4, SETTLE=2, TIMEOUT=8): directed
// timing scenarios plus randomized ready/retry/reset against a reference model.
module tb_reset_sequencer;

  localparam int NS      = 2;
  localparam int HOLD    = 4;
  localparam int SETTLE  = 2;
  localparam int TIMEOUT = 8;
  localparam int W       = NS + 5;

  localparam int P_HOLD   = 0;
  localparam int P_WAIT   = 1;
  localparam int P_SETTLE = 2;
  localparam int P_DONE   = 3;
  localparam int P_FAULT  = 4;

  logic clk;
  logic rst;

  reset_sequencer_if #(.NUM_STAGES(NS)) bus ();

  reset_sequencer #(
    .NUM_STAGES    (NS),
    .HOLD_CYCLES   (HOLD),
    .SETTLE_CYCLES (SETTLE),
    .TIMEOUT_CYCLES(TIMEOUT),
    .CNT_W         (24)
  ) dut (
    .iClk  (clk),
    .iReset(rst),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rst              = 1'b1;
    bus.iStage_Ready = '0;
    bus.iRetry       = 1'b0;
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  // Enables are always a contiguous prefix, so the model tracks only how many
  // stages are up and counts elapsed cycles in the current phase.
  int m_phase;
  int m_elapsed;
  int m_idx;
  int m_up;
  bit m_all;
  bit m_fault;
  int m_fstage;

  function automatic logic [W-1:0] model_out();
    logic [NS-1:0] en;
    en = NS'((1 << m_up) - 1);
    return {en, m_all, m_fault, 3'(m_fstage)};
  endfunction

  task automatic model_step(input logic [NS-1:0] rdy, input logic retry, input logic rs);
    if (rs) begin
      m_phase = P_HOLD; m_elapsed = 0; m_idx = 0; m_up = 0;
      m_all = 0; m_fault = 0; m_fstage = 0;
    end else begin
      case (m_phase)
        P_HOLD: begin
          if (m_elapsed == HOLD - 1) begin
            m_phase = P_WAIT; m_elapsed = 0; m_up = m_idx + 1;
          end else m_elapsed++;
        end
        P_WAIT: begin
          if (((rdy >> m_idx) & 1) != 0) begin
            m_phase = P_SETTLE; m_elapsed = 0;
          end else if (m_elapsed == TIMEOUT - 1) begin
            m_phase = P_FAULT; m_fault = 1; m_fstage = m_idx; m_up = 0;
          end else m_elapsed++;
        end
        P_SETTLE: begin
          if (m_elapsed == SETTLE - 1) begin
            if (m_idx == NS - 1) begin
              m_phase = P_DONE; m_all = 1;
            end else begin
              m_idx = m_idx + 1; m_up = m_idx + 1;
              m_phase = P_WAIT; m_elapsed = 0;
            end
          end else m_elapsed++;
        end
        P_DONE: begin
`ifdef RESET_SEQ_RESEQ_ON_LOSS_EN
          if (rdy != {NS{1'b1}}) begin
            int k;
            k = 0;
            while (((rdy >> k) & 1) != 0) k++;
            m_up = k; m_idx = k; m_all = 0;
            m_phase = P_HOLD; m_elapsed = 0;
          end
`endif
        end
        default: begin
          if (retry) begin
            m_phase = P_HOLD; m_elapsed = 0; m_idx = 0; m_fault = 0;
          end
        end
      endcase
    end
  endtask

  // ---------------- driver ----------------
  // Inputs for one cycle are applied on the falling edge; the expected outputs
  // after the following rising edge are queued at the same moment.
  task automatic drive(input logic [NS-1:0] rdy, input logic retry, input logic rs);
    @(negedge clk);
    bus.iStage_Ready = rdy;
    bus.iRetry       = retry;
    rst              = rs;
    model_step(rdy, retry, rs);
    exp_q.push_back(model_out());
  endtask

  function automatic logic [W-1:0] dut_out();
    return {bus.oReset_En, bus.oAll_Ready, bus.oFault, bus.oFault_Stage};
  endfunction

  task automatic check_out(input string name, input logic [W-1:0] exp);
    checks++;
    if (dut_out() !== exp) begin
      failures++;
      $display("FAIL %s: got en=%b all=%b fault=%b stage=%0d, expected en=%b all=%b fault=%b stage=%0d",
               name, bus.oReset_En, bus.oAll_Ready, bus.oFault, bus.oFault_Stage,
               exp[W-1 -: NS], exp[4], exp[3], exp[2:0]);
    end
  endtask

  task automatic do_reset();
    drive(2'b00, 1'b0, 1'b1);
    drive(2'b00, 1'b0, 1'b1);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [W-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (dut_out() !== e) begin
          failures++;
          $display("FAIL model @%0t: got %b, expected %b (en|all|fault|stage)", $time, dut_out(), e);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int p;
    logic [NS-1:0] r;

    // Ready tied high, then (DONE) a one-cycle loss of stage 1.
    do_reset();
    for (int c = 0; c <= 11; c++) begin
      drive(2'b11, 1'b0, 1'b0);
      if (c == 0)  check_out("reset_state", 7'b00_0_0_000);
      if (c == 3)  check_out("hold_end",    7'b00_0_0_000);
      if (c == 4)  check_out("en0_release", 7'b01_0_0_000);
      if (c == 6)  check_out("settle0_end", 7'b01_0_0_000);
      if (c == 7)  check_out("en1_release", 7'b11_0_0_000);
      if (c == 9)  check_out("settle1_end", 7'b11_0_0_000);
      if (c == 10) check_out("all_ready",   7'b11_1_0_000);
    end
    drive(2'b01, 1'b0, 1'b0);
    drive(2'b11, 1'b0, 1'b0);
`ifdef RESET_SEQ_RESEQ_ON_LOSS_EN
    check_out("loss_reseq", 7'b01_0_0_000);
`else
    check_out("loss_ignored", 7'b11_1_0_000);
`endif
    for (int c = 0; c < 7; c++) drive(2'b11, 1'b0, 1'b0);
    check_out("done_again", 7'b11_1_0_000);

    // Stage 1 never ready -> timeout, then retry.
    do_reset();
    for (int c = 0; c <= 15; c++) begin
      drive(2'b01, 1'b0, 1'b0);
      if (c == 14) check_out("wait1_last", 7'b11_0_0_000);
      if (c == 15) check_out("fault1",     7'b00_0_1_001);
    end
    drive(2'b01, 1'b0, 1'b0);
    check_out("fault_hold", 7'b00_0_1_001);
    drive(2'b11, 1'b1, 1'b0);
    for (int c = 1; c <= 11; c++) begin
      drive(2'b11, 1'b0, 1'b0);
      if (c == 1)  check_out("retry_clear", 7'b00_0_0_001);
      if (c == 5)  check_out("retry_en0",   7'b01_0_0_001);
      if (c == 8)  check_out("retry_en1",   7'b11_0_0_001);
      if (c == 11) check_out("retry_done",  7'b11_1_0_001);
    end

    // Stage 0 ready exactly on the last WAIT cycle (upper bit is don't-care).
    do_reset();
    for (int c = 0; c <= 17; c++) begin
      drive((c < 11) ? 2'b10 : 2'b11, 1'b0, 1'b0);
      if (c == 12) check_out("late_ready_ok", 7'b01_0_0_000);
      if (c == 14) check_out("late_en1",      7'b11_0_0_000);
      if (c == 17) check_out("late_done",     7'b11_1_0_000);
    end

    // Stage 0 ready one cycle too late -> fault on stage 0.
    do_reset();
    for (int c = 0; c <= 12; c++) begin
      drive((c < 12) ? 2'b00 : 2'b11, 1'b0, 1'b0);
      if (c == 12) check_out("fault0", 7'b00_0_1_000);
    end

    // Reset pulsed mid-SETTLE.
    do_reset();
    for (int c = 0; c <= 13; c++) begin
      drive(2'b11, 1'b0, (c == 8) ? 1'b1 : 1'b0);
      if (c == 8)  check_out("pre_reset",    7'b11_0_0_000);
      if (c == 9)  check_out("mid_reset",    7'b00_0_0_000);
      if (c == 12) check_out("rehold_end",   7'b00_0_0_000);
      if (c == 13) check_out("rehold_en0",   7'b01_0_0_000);
    end

    // Randomized ready / retry / reset traffic.
    p = 0;
    for (int i = 0; i < 1500; i++) begin
      if (i % 40 == 0) p = $urandom_range(0, 3);
      for (int b = 0; b < NS; b++) r[b] = ($urandom_range(0, 3) >= p);
      drive(r, ($urandom_range(0, 7) == 0), ($urandom_range(0, 299) == 0));
    end

    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
